// File: rtl/tsn_as_pkg.sv
// Shared definitions for the AS ingress arbiter: FSM encoding, abort-beat
// constants and the port-index width helper.
package tsn_as_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_META  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ABORT = 2'd3
    } as_state_t;

    localparam logic        ABORT_CRCERR  = 1'b1;
    localparam logic        ABORT_LAST    = 1'b1;
    localparam logic [15:0] ABORT_CNT_MAX = 16'hFFFF;

    function automatic int port_id_width(input int port_num);
        return (port_num > 1) ? $clog2(port_num) : 1;
    endfunction

endpackage

// File: rtl/tsn_as_rx_arbiter_rr_picker.sv
// Combinational round-robin first-one finder: scans i_req from i_ptr upward
// with wrap and returns the first set index.
module tsn_as_rr_picker #(
    parameter int NUM = 8,
    parameter int IDW = 3
) (
    input  logic [NUM-1:0] i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= NUM) ? (sum - NUM) : sum;
        return sum[IDW-1:0];
    endfunction

    // first requesting port at or after the pointer, wrapping at NUM-1
    always_comb begin
        logic [IDW-1:0] cand;
        logic           hit;
        cand  = {IDW{1'b0}};
        hit   = 1'b0;
        o_idx = {IDW{1'b0}};
        o_any = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            cand  = wrap_add(i_ptr, k);
            hit   = i_req[cand] & ~o_any;
            o_idx = hit ? cand : o_idx;
            o_any = o_any | hit;
        end
    end

endmodule

// File: rtl/tsn_as_rx_arbiter.sv
// N-port frame-atomic round-robin aggregator feeding the AS protocol engine,
// with ingress timestamp capture and clean abort on source link loss.
module tsn_as_rx_arbiter
    import tsn_as_pkg::*;
#(
    parameter int PORT_NUM         = 8,
    parameter int CROSS_DATA_WIDTH = 8,
    parameter int METADATA_WIDTH   = 64,
    parameter int TIMESTAMP_WIDTH  = 80,
    parameter int PORT_ID_WIDTH    = port_id_width(PORT_NUM)
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic [PORT_NUM-1:0]                        i_port_en,
    input  logic [PORT_NUM-1:0]                        i_port_link,
    input  logic [PORT_NUM*(CROSS_DATA_WIDTH+1)-1:0]   i_axi_data,
    input  logic [PORT_NUM*(CROSS_DATA_WIDTH/8)-1:0]   i_axi_keep,
    input  logic [PORT_NUM-1:0]                        i_axi_valid,
    input  logic [PORT_NUM-1:0]                        i_axi_last,
    output logic [PORT_NUM-1:0]                        o_axi_ready,
    input  logic [PORT_NUM*METADATA_WIDTH-1:0]         i_meta,
    input  logic [PORT_NUM-1:0]                        i_meta_valid,
    input  logic [PORT_NUM-1:0]                        i_meta_last,
    output logic [PORT_NUM-1:0]                        o_meta_ready,
    output logic [CROSS_DATA_WIDTH:0]                  o_axi_data,
    output logic [CROSS_DATA_WIDTH/8-1:0]              o_axi_keep,
    output logic                                       o_axi_valid,
    output logic                                       o_axi_last,
    input  logic                                       i_axi_ready,
    output logic [METADATA_WIDTH-1:0]                  o_meta,
    output logic                                       o_meta_valid,
    output logic                                       o_meta_last,
    input  logic                                       i_meta_ready,
    output logic                                       o_link,
    input  logic [TIMESTAMP_WIDTH-1:0]                 i_local_ts,
    output logic [TIMESTAMP_WIDTH-1:0]                 o_ts_capture,
    output logic [PORT_ID_WIDTH-1:0]                   o_ts_port,
    output logic                                       o_ts_valid,
    input  logic                                       i_err_cnt_clr,
    output logic [15:0]                                o_abort_cnt
);

    localparam int DW1 = CROSS_DATA_WIDTH + 1;
    localparam int KW  = CROSS_DATA_WIDTH / 8;

    as_state_t                  r_state, w_state_nxt;
    logic [PORT_ID_WIDTH-1:0]   r_grant, w_grant_nxt;
    logic [PORT_ID_WIDTH-1:0]   r_rr, w_rr_nxt;
    logic [PORT_ID_WIDTH-1:0]   w_grant_inc;
    logic [PORT_ID_WIDTH-1:0]   w_pick_idx;
    logic                       w_pick_any;
    logic [PORT_NUM-1:0]        w_elig;
    logic                       r_abort_meta, w_abort_meta_nxt;
    logic                       r_first, w_first_nxt;
    logic                       w_capture;
    logic                       w_abort_evt;
    logic [TIMESTAMP_WIDTH-1:0] r_ts_capture;
    logic [PORT_ID_WIDTH-1:0]   r_ts_port;
    logic                       r_ts_valid;
    logic [15:0]                r_abort_cnt;

    logic [DW1-1:0]             w_data_arr [PORT_NUM];
    logic [KW-1:0]              w_keep_arr [PORT_NUM];
    logic [METADATA_WIDTH-1:0]  w_meta_arr [PORT_NUM];

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_unpack
        assign w_data_arr[p] = i_axi_data[p*DW1 +: DW1];
        assign w_keep_arr[p] = i_axi_keep[p*KW +: KW];
        assign w_meta_arr[p] = i_meta[p*METADATA_WIDTH +: METADATA_WIDTH];
    end

    assign w_elig      = i_meta_valid & i_port_link & i_port_en;
    assign o_link      = |(i_port_link & i_port_en);
    assign w_grant_inc = (r_grant == PORT_ID_WIDTH'(PORT_NUM - 1)) ?
                         {PORT_ID_WIDTH{1'b0}} : (r_grant + PORT_ID_WIDTH'(1));

    tsn_as_rr_picker #(
        .NUM (PORT_NUM),
        .IDW (PORT_ID_WIDTH)
    ) u_picker (
        .i_req (w_elig),
        .i_ptr (r_rr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // next-state decode and granted-port stream mux
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_rr_nxt         = r_rr;
        w_abort_meta_nxt = r_abort_meta;
        w_first_nxt      = r_first;
        w_capture        = 1'b0;
        w_abort_evt      = 1'b0;
        o_axi_ready      = {PORT_NUM{1'b0}};
        o_meta_ready     = {PORT_NUM{1'b0}};
        o_axi_data       = {DW1{1'b0}};
        o_axi_keep       = {KW{1'b0}};
        o_axi_valid      = 1'b0;
        o_axi_last       = 1'b0;
        o_meta           = {METADATA_WIDTH{1'b0}};
        o_meta_valid     = 1'b0;
        o_meta_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_META;
                    w_grant_nxt = w_pick_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_META: begin
                if (!i_port_link[r_grant]) begin
                    w_state_nxt      = ST_ABORT;
                    w_abort_meta_nxt = 1'b1;
                    w_abort_evt      = 1'b1;
                end else begin
                    o_meta                = w_meta_arr[r_grant];
                    o_meta_valid          = i_meta_valid[r_grant];
                    o_meta_last           = i_meta_last[r_grant];
                    o_meta_ready[r_grant] = i_meta_ready;
                    if (i_meta_valid[r_grant] && i_meta_ready && i_meta_last[r_grant]) begin
                        w_state_nxt = ST_DATA;
                        w_first_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_META;
                    end
                end
            end
            ST_DATA: begin
                if (!i_port_link[r_grant]) begin
                    w_state_nxt      = ST_ABORT;
                    w_abort_meta_nxt = 1'b0;
                    w_abort_evt      = 1'b1;
                end else begin
                    o_axi_data           = w_data_arr[r_grant];
                    o_axi_keep           = w_keep_arr[r_grant];
                    o_axi_valid          = i_axi_valid[r_grant];
                    o_axi_last           = i_axi_last[r_grant];
                    o_axi_ready[r_grant] = i_axi_ready;
                    if (i_axi_valid[r_grant] && i_axi_ready) begin
                        w_capture   = r_first;
                        w_first_nxt = 1'b0;
                        if (i_axi_last[r_grant]) begin
                            w_state_nxt = ST_IDLE;
                            w_rr_nxt    = w_grant_inc;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_ABORT: begin
                // an unfinished metadata frame is closed before the poisoned data beat
                if (r_abort_meta) begin
                    o_meta_valid = 1'b1;
                    o_meta_last  = ABORT_LAST;
                    if (i_meta_ready) begin
                        w_abort_meta_nxt = 1'b0;
                    end else begin
                        w_abort_meta_nxt = 1'b1;
                    end
                end else begin
                    o_axi_valid = 1'b1;
                    o_axi_last  = ABORT_LAST;
                    o_axi_data  = {ABORT_CRCERR, {CROSS_DATA_WIDTH{1'b0}}};
                    if (i_axi_ready) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = w_grant_inc;
                    end else begin
                        w_state_nxt = ST_ABORT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and round-robin pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= {PORT_ID_WIDTH{1'b0}};
            r_rr         <= {PORT_ID_WIDTH{1'b0}};
            r_abort_meta <= 1'b0;
            r_first      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_rr         <= w_rr_nxt;
            r_abort_meta <= w_abort_meta_nxt;
            r_first      <= w_first_nxt;
        end
    end

    // ingress timestamp capture on the first accepted data beat of a frame
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ts_capture <= {TIMESTAMP_WIDTH{1'b0}};
            r_ts_port    <= {PORT_ID_WIDTH{1'b0}};
            r_ts_valid   <= 1'b0;
        end else begin
            r_ts_valid <= w_capture;
            if (w_capture) begin
                r_ts_capture <= i_local_ts;
                r_ts_port    <= r_grant;
            end
        end
    end

    // saturating abort counter; a clear in the same cycle as an abort wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_abort_cnt <= 16'h0000;
        end else if (i_err_cnt_clr) begin
            r_abort_cnt <= 16'h0000;
        end else if (w_abort_evt && (r_abort_cnt != ABORT_CNT_MAX)) begin
            r_abort_cnt <= r_abort_cnt + 16'h0001;
        end
    end

    assign o_ts_capture = r_ts_capture;
    assign o_ts_port    = r_ts_port;
    assign o_ts_valid   = r_ts_valid;
    assign o_abort_cnt  = r_abort_cnt;

endmodule

// File: tb/tb_tsn_as_rx_arbiter.sv
// Directed scoreboard bench for tsn_as_rx_arbiter: per-port source models feed
// frames, expected merged beats and timestamps are queued and compared on output.
module tb_tsn_as_rx_arbiter;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int DW1 = DW + 1;
    localparam int MW  = 64;
    localparam int TW  = 80;
    localparam int PW  = 3;

    logic              clk;
    logic              i_rst;
    logic [N-1:0]      i_port_en, i_port_link;
    logic [N*DW1-1:0]  i_axi_data;
    logic [N-1:0]      i_axi_keep, i_axi_valid, i_axi_last, o_axi_ready;
    logic [N*MW-1:0]   i_meta;
    logic [N-1:0]      i_meta_valid, i_meta_last, o_meta_ready;
    logic [DW1-1:0]    o_axi_data;
    logic [0:0]        o_axi_keep;
    logic              o_axi_valid, o_axi_last, i_axi_ready;
    logic [MW-1:0]     o_meta;
    logic              o_meta_valid, o_meta_last, i_meta_ready;
    logic              o_link;
    logic [TW-1:0]     i_local_ts, o_ts_capture;
    logic [PW-1:0]     o_ts_port;
    logic              o_ts_valid, i_err_cnt_clr;
    logic [15:0]       o_abort_cnt;

    tsn_as_rx_arbiter #(
        .PORT_NUM(N), .CROSS_DATA_WIDTH(DW), .METADATA_WIDTH(MW), .TIMESTAMP_WIDTH(TW)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_port_en(i_port_en), .i_port_link(i_port_link),
        .i_axi_data(i_axi_data), .i_axi_keep(i_axi_keep), .i_axi_valid(i_axi_valid),
        .i_axi_last(i_axi_last), .o_axi_ready(o_axi_ready), .i_meta(i_meta),
        .i_meta_valid(i_meta_valid), .i_meta_last(i_meta_last), .o_meta_ready(o_meta_ready),
        .o_axi_data(o_axi_data), .o_axi_keep(o_axi_keep), .o_axi_valid(o_axi_valid),
        .o_axi_last(o_axi_last), .i_axi_ready(i_axi_ready), .o_meta(o_meta),
        .o_meta_valid(o_meta_valid), .o_meta_last(o_meta_last), .i_meta_ready(i_meta_ready),
        .o_link(o_link), .i_local_ts(i_local_ts), .o_ts_capture(o_ts_capture),
        .o_ts_port(o_ts_port), .o_ts_valid(o_ts_valid), .i_err_cnt_clr(i_err_cnt_clr),
        .o_abort_cnt(o_abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // source models: {last, keep, crcerr, byte} and {last, meta}
    logic [10:0] d_mem [N][64];
    logic [64:0] m_mem [N][16];
    int          d_wr [N], d_rd [N], m_wr [N], m_rd [N];
    bit          nf   [N];
    logic [63:0] ts_cnt;

    logic [10:0] exp_d  [$];
    logic [64:0] exp_m  [$];
    logic [82:0] exp_ts [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] dbeat(input int p, input int i, input int n, input int tag);
        logic [7:0] b;
        b = 8'((p << 4) + i * 3 + tag * 11);
        return {(i == n - 1), 1'b1, 1'b0, b};
    endfunction

    function automatic logic [64:0] mbeat(input int p, input int i, input int n, input int tag);
        return {(i == n - 1), 16'hCAFE, 16'(tag), 16'(p), 16'(i)};
    endfunction

    task automatic load_frame(input int p, input int nm, input int nd, input int tag);
        for (int i = 0; i < nm; i++) begin
            m_mem[p][m_wr[p]] = mbeat(p, i, nm, tag);
            m_wr[p]++;
        end
        for (int i = 0; i < nd; i++) begin
            d_mem[p][d_wr[p]] = dbeat(p, i, nd, tag);
            d_wr[p]++;
        end
    endtask

    task automatic push_exp(input int p, input int nm_out, input int nd_out,
                            input int nm, input int nd, input int tag);
        for (int i = 0; i < nm_out; i++) exp_m.push_back(mbeat(p, i, nm, tag));
        for (int i = 0; i < nd_out; i++) exp_d.push_back(dbeat(p, i, nd, tag));
    endtask

    task automatic push_abort(input bit with_meta);
        if (with_meta) exp_m.push_back({1'b1, 64'h0});
        exp_d.push_back({1'b1, 1'b0, 1'b1, 8'h00});
    endtask

    task automatic flush(input int p);
        d_rd[p] = d_wr[p];
        m_rd[p] = m_wr[p];
        nf[p]   = 1'b1;
    endtask

    function automatic bit srcs_empty();
        bit e;
        e = 1'b1;
        for (int p = 0; p < N; p++) e = e & (d_rd[p] == d_wr[p]) & (m_rd[p] == m_wr[p]);
        return e;
    endfunction

    task automatic wait_drain(input int max_cyc, input bit toggle);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (toggle) i_axi_ready = ~i_axi_ready;
            done = (exp_d.size() == 0) && (exp_m.size() == 0) && (exp_ts.size() == 0) && srcs_empty();
        end
        i_axi_ready = 1'b1;
        chk("drain_timeout", {127'd0, done}, 128'd1);
    endtask

    task automatic wait_ptr(input int p, input bit meta, input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = meta ? (m_rd[p] >= target) : (d_rd[p] >= target);
        end
        chk("wait_ptr_timeout", {127'd0, ok}, 128'd1);
    endtask

    // source driver and output monitor
    initial begin
        i_axi_data = '0; i_axi_keep = '0; i_axi_valid = '0; i_axi_last = '0;
        i_meta = '0; i_meta_valid = '0; i_meta_last = '0;
        ts_cnt = 64'd0; i_local_ts = '0;
        forever begin
            @(posedge clk);
            #2;
            ts_cnt     = ts_cnt + 64'd1;
            i_local_ts = {16'hA5A5, ts_cnt};
            for (int p = 0; p < N; p++) begin
                i_axi_valid[p] = (d_rd[p] < d_wr[p]);
                if (d_rd[p] < d_wr[p]) begin
                    i_axi_data[p*DW1 +: DW1] = d_mem[p][d_rd[p]][8:0];
                    i_axi_keep[p] = d_mem[p][d_rd[p]][9];
                    i_axi_last[p] = d_mem[p][d_rd[p]][10];
                end
                i_meta_valid[p] = (m_rd[p] < m_wr[p]);
                if (m_rd[p] < m_wr[p]) begin
                    i_meta[p*MW +: MW] = m_mem[p][m_rd[p]][63:0];
                    i_meta_last[p] = m_mem[p][m_rd[p]][64];
                end
            end
            @(negedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (i_axi_valid[p] && o_axi_ready[p]) begin
                    if (nf[p]) exp_ts.push_back({PW'(p), i_local_ts});
                    nf[p] = i_axi_last[p];
                    d_rd[p]++;
                end
                if (i_meta_valid[p] && o_meta_ready[p]) m_rd[p]++;
            end
            if (o_meta_valid && i_meta_ready) begin
                if (exp_m.size() == 0) chk("meta_extra", {63'd0, o_meta_last, o_meta}, 128'd0);
                else chk("meta_beat", {63'd0, o_meta_last, o_meta}, {63'd0, exp_m.pop_front()});
            end
            if (o_axi_valid && i_axi_ready) begin
                if (exp_d.size() == 0) chk("data_extra", {117'd0, o_axi_last, o_axi_keep, o_axi_data}, 128'd0);
                else chk("data_beat", {117'd0, o_axi_last, o_axi_keep, o_axi_data}, {117'd0, exp_d.pop_front()});
            end
            if (o_ts_valid) begin
                if (exp_ts.size() == 0) chk("ts_extra", {45'd0, o_ts_port, o_ts_capture}, 128'd0);
                else chk("ts_capture", {45'd0, o_ts_port, o_ts_capture}, {45'd0, exp_ts.pop_front()});
            end
        end
    end

    // directed sequence
    initial begin
        int base;
        i_rst = 1'b1; i_port_en = 8'hFF; i_port_link = 8'hFF;
        i_axi_ready = 1'b1; i_meta_ready = 1'b1; i_err_cnt_clr = 1'b0;
        for (int p = 0; p < N; p++) begin
            d_wr[p] = 0; d_rd[p] = 0; m_wr[p] = 0; m_rd[p] = 0; nf[p] = 1'b1;
        end
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valids", {124'd0, o_axi_valid, o_axi_last, o_meta_valid, o_ts_valid}, 128'd0);
        chk("rst_readies", {112'd0, o_axi_ready, o_meta_ready}, 128'd0);
        chk("rst_ts", {45'd0, o_ts_port, o_ts_capture}, 128'd0);
        chk("rst_abort_cnt", {112'd0, o_abort_cnt}, 128'd0);
        chk("rst_link", {127'd0, o_link}, 128'd1);
        @(negedge clk);
        i_rst = 1'b0;

        // ports 0,3,5 request together from rr=0
        @(negedge clk);
        load_frame(0, 1, 4, 1); load_frame(3, 1, 4, 1); load_frame(5, 1, 4, 1);
        push_exp(0, 1, 4, 1, 4, 1); push_exp(3, 1, 4, 1, 4, 1); push_exp(5, 1, 4, 1, 4, 1);
        wait_drain(200, 1'b0);

        // 6-beat frame with toggling downstream ready
        load_frame(2, 1, 6, 2);
        push_exp(2, 1, 6, 1, 6, 2);
        wait_drain(200, 1'b1);

        // link drop on port 1 after 2 of 5 data beats; port 2 follows
        base = d_wr[1];
        load_frame(1, 1, 5, 3); load_frame(2, 1, 4, 4);
        push_exp(1, 1, 2, 1, 5, 3); push_abort(1'b0); push_exp(2, 1, 4, 1, 4, 4);
        wait_ptr(1, 1'b0, base + 2);
        i_port_link[1] = 1'b0;
        flush(1);
        wait_drain(200, 1'b0);
        chk("abort_cnt_data", {112'd0, o_abort_cnt}, 128'd1);
        i_port_link[1] = 1'b1;

        // link drop on port 4 in the middle of a 3-beat metadata frame
        base = m_wr[4];
        load_frame(4, 3, 2, 5);
        push_exp(4, 1, 0, 3, 2, 5); push_abort(1'b1);
        wait_ptr(4, 1'b1, base + 1);
        i_port_link[4] = 1'b0;
        flush(4);
        wait_drain(200, 1'b0);
        chk("abort_cnt_meta", {112'd0, o_abort_cnt}, 128'd2);
        i_port_link[4] = 1'b1;

        // abort coinciding with a counter clear
        base = d_wr[3];
        load_frame(3, 1, 4, 6);
        push_exp(3, 1, 1, 1, 4, 6); push_abort(1'b0);
        wait_ptr(3, 1'b0, base + 1);
        i_port_link[3] = 1'b0; i_err_cnt_clr = 1'b1;
        flush(3);
        @(negedge clk);
        i_err_cnt_clr = 1'b0;
        wait_drain(200, 1'b0);
        chk("abort_cnt_clr_wins", {112'd0, o_abort_cnt}, 128'd0);
        i_port_link[3] = 1'b1;

        // disabled port 0 must not be granted; enabling it grants in one cycle
        i_port_en = 8'hFE; i_port_link = 8'h01;
        load_frame(0, 1, 2, 7);
        push_exp(0, 1, 2, 1, 2, 7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            chk("disabled_no_grant", {119'd0, o_meta_valid, o_meta_ready}, 128'd0);
            chk("disabled_link", {127'd0, o_link}, 128'd0);
        end
        @(negedge clk);
        i_port_en = 8'hFF;
        @(negedge clk);
        #2;
        chk("enable_grant_latency", {127'd0, o_meta_valid}, 128'd1);
        chk("enable_link", {127'd0, o_link}, 128'd1);
        wait_drain(200, 1'b0);
        i_port_link = 8'hFF;

        // asynchronous reset in the middle of a data frame
        base = d_wr[6];
        load_frame(6, 1, 8, 8);
        push_exp(6, 1, 8, 1, 8, 8);
        wait_ptr(6, 1'b0, base + 2);
        i_rst = 1'b1;
        #1;
        chk("rst_mid_valids", {124'd0, o_axi_valid, o_axi_last, o_meta_valid, o_ts_valid}, 128'd0);
        chk("rst_mid_readies", {112'd0, o_axi_ready, o_meta_ready}, 128'd0);
        chk("rst_mid_ts", {45'd0, o_ts_port, o_ts_capture}, 128'd0);
        flush(6);
        exp_d.delete(); exp_m.delete(); exp_ts.delete();
        @(negedge clk);
        i_rst = 1'b0;

        // after reset the pointer is back at 0: port 0 before port 7
        @(negedge clk);
        load_frame(7, 1, 3, 10); load_frame(0, 1, 3, 9);
        push_exp(0, 1, 3, 1, 3, 9); push_exp(7, 1, 3, 1, 3, 10);
        wait_drain(200, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
